// File: rtl/pixel_cfg_sequencer.sv
// pixel_cfg_sequencer: shifts one configuration word into the Mic4 pixel
// matrix chain on a divided bit clock, then strobes the chip latches.
module pixel_cfg_sequencer #(
    parameter int DIV    = 5,
    parameter int NBITS  = 32,
    parameter int LOAD_W = 2
) (
    input  logic                       clkin,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       msb_first,
    input  logic [NBITS-1:0]           cfg_word,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_sclk,
    output logic                       cfg_sdata,
    output logic                       cfg_load,
    output logic [$clog2(NBITS+1)-1:0] bit_idx
);
    localparam int PW = $clog2(DIV);
    localparam int LW = $clog2(LOAD_W + 1);
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [LW-1:0] LD_LAST = LW'(LOAD_W - 1);
    localparam logic [BW-1:0] BI_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_ph;
    logic [PW-1:0]    w_ph_nxt;
    logic [LW-1:0]    r_lcnt;
    logic [LW-1:0]    w_lcnt_nxt;
    logic [NBITS-1:0] r_sh;
    logic [NBITS-1:0] w_sh_nxt;
    logic             r_msb;
    logic             w_msb_nxt;
    logic [BW-1:0]    r_bi;
    logic [BW-1:0]    w_bi_nxt;

    logic             w_per_end;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic             w_sclk;
    logic             w_sdata;
    logic             w_load;

    logic             r_busy;
    logic             r_done;
    logic             r_sclk;
    logic             r_sdata;
    logic             r_load;

    assign w_per_end = (r_ph == PH_LAST);
    // abort beats a simultaneous start while idle
    assign w_accept  = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort) w_state_nxt = S_IDLE;
                else if (w_per_end && r_bi == BI_LAST) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (abort) w_state_nxt = S_IDLE;
                else if (w_per_end && r_lcnt == LD_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // bit data advances only at a period boundary, so sdata is stable under sclk high
    always_comb begin
        w_ph_nxt   = '0;
        w_lcnt_nxt = '0;
        w_sh_nxt   = r_sh;
        w_msb_nxt  = r_msb;
        w_bi_nxt   = r_bi;
        if (w_accept) begin
            w_sh_nxt  = cfg_word;
            w_msb_nxt = msb_first;
            w_bi_nxt  = '0;
        end else if (r_state != S_IDLE && !abort) begin
            w_ph_nxt = w_per_end ? '0 : r_ph + 1'b1;
            if (r_state == S_LOAD) begin
                w_lcnt_nxt = r_lcnt + LW'(w_per_end);
            end else if (w_per_end) begin
                w_bi_nxt = r_bi + 1'b1;
                w_sh_nxt = r_msb ? (r_sh << 1) : (r_sh >> 1);
            end
        end
    end

    always_comb begin
        w_busy  = (w_state_nxt != S_IDLE);
        w_done  = (r_state == S_LOAD) && (w_state_nxt == S_IDLE) && !abort;
        w_sclk  = (w_state_nxt == S_SHIFT) && (w_ph_nxt >= PH_HALF);
        w_sdata = (w_state_nxt == S_SHIFT) &&
                  (w_msb_nxt ? w_sh_nxt[NBITS-1] : w_sh_nxt[0]);
        w_load  = (w_state_nxt == S_LOAD);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_ph    <= '0;
            r_lcnt  <= '0;
            r_sh    <= '0;
            r_msb   <= 1'b0;
            r_bi    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_ph    <= w_ph_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_sh    <= w_sh_nxt;
            r_msb   <= w_msb_nxt;
            r_bi    <= w_bi_nxt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_sclk  <= w_sclk;
            r_sdata <= w_sdata;
            r_load  <= w_load;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_sclk  = r_sclk;
    assign cfg_sdata = r_sdata;
    assign cfg_load  = r_load;
    assign bit_idx   = r_bi;

endmodule

// File: tb/tb_pixel_cfg_sequencer.sv
// tb_pixel_cfg_sequencer: vector table, corner sequences and a randomized
// run against a cycle-offset reference model.
module tb_pixel_cfg_sequencer;
    localparam int NB = 8;
    localparam int LW = 2;
    localparam int DA = 5;
    localparam int DB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, abort_a, msb_a;
    logic [7:0] word_a;
    logic       busy_a, done_a, sclk_a, sdata_a, load_a;
    logic [3:0] bi_a;

    logic       rst_b, start_b, abort_b, msb_b;
    logic [7:0] word_b;
    logic       busy_b, done_b, sclk_b, sdata_b, load_b;
    logic [3:0] bi_b;

    logic [8:0] va, vb;
    assign va = {busy_a, done_a, sclk_a, sdata_a, load_a, bi_a};
    assign vb = {busy_b, done_b, sclk_b, sdata_b, load_b, bi_b};

    pixel_cfg_sequencer #(.DIV(DA), .NBITS(NB), .LOAD_W(LW)) u_a (
        .clkin(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
        .msb_first(msb_a), .cfg_word(word_a), .busy(busy_a), .done(done_a),
        .cfg_sclk(sclk_a), .cfg_sdata(sdata_a), .cfg_load(load_a),
        .bit_idx(bi_a)
    );

    pixel_cfg_sequencer #(.DIV(DB), .NBITS(NB), .LOAD_W(LW)) u_b (
        .clkin(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
        .msb_first(msb_b), .cfg_word(word_b), .busy(busy_b), .done(done_b),
        .cfg_sclk(sclk_b), .cfg_sdata(sdata_b), .cfg_load(load_b),
        .bit_idx(bi_b)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] word;
        logic       msb;
        logic [7:0] seq;
    } vec_t;
    vec_t tbl[7];

    logic       m_act, m_done;
    int         m_k;
    logic [7:0] m_seq;
    logic [3:0] m_bi;
    logic [8:0] m_exp;

    task automatic chk(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (busy,done,sclk,sdata,load,idx)",
                     name, act, exp);
        end
    endtask

    // expected outputs k cycles after start was accepted; seq[7] goes first
    function automatic logic [8:0] exp_vec(input int div, input int k,
                                           input logic [7:0] seq);
        int tsh;
        int tt;
        int b;
        tsh = NB * div;
        tt  = (NB + LW) * div;
        if (k <= tsh) begin
            b = (k - 1) / div;
            return {1'b1, 1'b0, (((k - 1) % div) >= div / 2), seq[7-b],
                    1'b0, 4'(b)};
        end
        if (k <= tt) return {5'b10001, 4'(NB)};
        return {5'b01000, 4'(NB)};
    endfunction

    function automatic logic [7:0] order(input logic [7:0] w, input logic m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return m ? w : r;
    endfunction

    task automatic go_a(input logic [7:0] w, input logic m);
        word_a  = w;
        msb_a   = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic run_a(input logic [7:0] seq, input int mid_at,
                         input bit b2b, input logic [7:0] nw,
                         input logic nm, input string tag);
        int tt;
        tt = (NB + LW) * DA;
        for (int c = 1; c <= tt + 1; c++) begin
            chk($sformatf("%s c%0d", tag, c), va, exp_vec(DA, c, seq));
            start_a = 1'b0;
            if (c == mid_at) begin
                start_a = 1'b1;
                word_a  = 8'hFF;
                msb_a   = 1'b1;
            end
            if (b2b && c == tt + 1) begin
                start_a = 1'b1;
                word_a  = nw;
                msb_a   = nm;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; msb_a = 1'b0;
        word_a = 8'h00;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; msb_b = 1'b0;
        word_b = 8'h00;

        tbl[0] = '{8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{8'h01, 1'b1, 8'h01};
        tbl[2] = '{8'h01, 1'b0, 8'h80};
        tbl[3] = '{8'h80, 1'b0, 8'h01};
        tbl[4] = '{8'h0F, 1'b0, 8'hF0};
        tbl[5] = '{8'hC2, 1'b1, 8'hC2};
        tbl[6] = '{8'hC2, 1'b0, 8'h43};

        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", va, 9'd0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("rst_idle %0d", i), va, 9'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 7; i++) begin
            go_a(tbl[i].word, tbl[i].msb);
            run_a(tbl[i].seq, 0, 1'b0, 8'h00, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d hold", i), va, {5'b0, 4'd8});
        end

        go_a(8'hA5, 1'b1);
        run_a(8'hA5, 10, 1'b0, 8'h00, 1'b0, "busy_start");
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("no_second %0d", i), va, {5'b0, 4'd8});
            @(negedge clk);
        end

        go_a(8'hC2, 1'b1);
        run_a(8'hC2, 0, 1'b1, 8'h01, 1'b0, "b2b1");
        run_a(8'h80, 0, 1'b0, 8'h00, 1'b0, "b2b2");

        go_a(8'hA5, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("abort c%0d", c), va, exp_vec(DA, c, 8'hA5));
            if (c == 16) abort_a = 1'b1;
            @(negedge clk);
        end
        abort_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("abort_after %0d", i), va, {5'b0, 4'd3});
            @(negedge clk);
        end

        go_a(8'hA5, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("mrst c%0d", c), va, exp_vec(DA, c, 8'hA5));
            if (c == 16) rst_a = 1'b1;
            @(negedge clk);
        end
        rst_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("mrst_after %0d", i), va, 9'd0);
            @(negedge clk);
        end

        start_a = 1'b1;
        abort_a = 1'b1;
        word_a  = 8'hFF;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("abort_wins %0d", i), va, 9'd0);
            @(negedge clk);
        end

        word_b  = 8'h01;
        msb_b   = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 1; c <= (NB + LW) * DB + 1; c++) begin
            chk($sformatf("div2 c%0d", c), vb, exp_vec(DB, c, 8'h80));
            @(negedge clk);
        end
        chk("div2 hold", vb, {5'b0, 4'd8});

        rst_a = 1'b1;
        @(negedge clk);
        m_act  = 1'b0;
        m_done = 1'b0;
        m_bi   = 4'd0;
        m_k    = 0;
        m_seq  = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            m_exp = m_act ? exp_vec(DA, m_k, m_seq) : {1'b0, m_done, 3'b0, m_bi};
            chk($sformatf("rand n%0d", n), va, m_exp);
            rst_a   = ($urandom_range(0, 299) == 0);
            abort_a = ($urandom_range(0, 79) == 0);
            start_a = ($urandom_range(0, 3) == 0);
            word_a  = 8'($urandom);
            msb_a   = 1'($urandom);
            if (rst_a) begin
                m_act  = 1'b0;
                m_done = 1'b0;
                m_bi   = 4'd0;
            end else if (m_act) begin
                if (abort_a) begin
                    m_act  = 1'b0;
                    m_done = 1'b0;
                    m_bi   = m_exp[3:0];
                end else if (m_k == (NB + LW) * DA) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                    m_bi   = 4'(NB);
                end else begin
                    m_k++;
                end
            end else begin
                m_done = 1'b0;
                if (start_a && !abort_a) begin
                    m_act = 1'b1;
                    m_k   = 1;
                    m_seq = order(word_a, msb_a);
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
